prism_cfg_seq: RTL and testbench

PRISM_CFG_SEQ -- requirements
Module: prism_cfg_seq

---
 rtl/prism_pkg.sv | 18 +
 rtl/prism_cmd_fifo.sv | 49 ++++
 rtl/prism_cfg_seq.sv | 98 +++++++++
 tb/tb_prism_cfg_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prism_pkg.sv
// prism_pkg: shared types and defaults for the PRISM config sequencer.
package prism_pkg;
    localparam int DEPTH_DEF        = 4;
    localparam int HALT_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_HALT = 3'd1,
        WRITE    = 3'd2,
        RESUME   = 3'd3,
        FLUSH    = 3'd4
    } state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } cmd_t;
endpackage

// File: rtl/prism_cmd_fifo.sv
// prism_cmd_fifo: command FIFO with single-cycle clear and occupancy output.
module prism_cmd_fifo
    import prism_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clr,
    input  cmd_t       wdata,
    output cmd_t       rdata,
    output logic       full,
    output logic       empty,
    output logic [3:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] FULL_LVL = 4'(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [3:0]    cnt_q;
    logic          push_ok, pop_ok;

    assign full    = cnt_q == FULL_LVL;
    assign empty   = cnt_q == 4'd0;
    assign level   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + 4'(push_ok) - 4'(pop_ok);
        end
    end
endmodule

// File: rtl/prism_cfg_seq.sv
// prism_cfg_seq: queues host config writes and replays them into PRISM debug
// registers, halting the engine first when it is running.
module prism_cfg_seq
    import prism_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int HALT_TIMEOUT = HALT_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        exec_active,
    input  logic        halted,
    output logic        halt_req,
    output logic [5:0]  dbg_addr,
    output logic        dbg_wr,
    output logic [31:0] dbg_wdata,
    input  logic        err_clr,
    output logic        busy,
    output logic        timeout_err,
    output logic [3:0]  level
);
    localparam logic [7:0] CNT_LAST = 8'(HALT_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       owned_q, owned_d;
    logic       err_q, err_d;
    logic       push, pop, full, empty;
    cmd_t       head;

    prism_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clr   (state_q == FLUSH),
        .wdata ('{addr: cmd_addr, data: cmd_data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owned_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owned_q <= owned_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owned_d = owned_q;
        case (state_q)
            IDLE: if (!empty) begin
                state_d = exec_active ? REQ_HALT : WRITE;
                owned_d = exec_active;
                cnt_d   = '0;
            end
            REQ_HALT: begin
                state_d = halted ? WRITE : (cnt_q == CNT_LAST) ? FLUSH : REQ_HALT;
                cnt_d   = cnt_q + 8'd1;
            end
            // A push landing with the pop keeps the burst going.
            WRITE: state_d = (level > 4'd1 || push) ? WRITE : RESUME;
            RESUME, FLUSH: begin
                state_d = IDLE;
                owned_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = !full && state_q != FLUSH;
        push        = cmd_valid && cmd_ready;
        pop         = state_q == WRITE;
        dbg_wr      = pop;
        dbg_addr    = pop ? head.addr : '0;
        dbg_wdata   = pop ? head.data : '0;
        halt_req    = state_q == REQ_HALT || (state_q == WRITE && owned_q);
        busy        = state_q != IDLE || !empty;
        timeout_err = err_q;
        err_d       = state_q == FLUSH || (err_q && !err_clr);
    end
endmodule

// File: tb/tb_prism_cfg_seq.sv
// tb_prism_cfg_seq: directed scenarios for the PRISM config sequencer.
module tb_prism_cfg_seq;
    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, exec_active, halted, halt_req;
    logic        dbg_wr, err_clr, busy, timeout_err;
    logic [5:0]  cmd_addr, dbg_addr;
    logic [31:0] cmd_data, dbg_wdata;
    logic [3:0]  level;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    prism_cfg_seq #(.DEPTH(4), .HALT_TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .exec_active (exec_active),
        .halted      (halted),
        .halt_req    (halt_req),
        .dbg_addr    (dbg_addr),
        .dbg_wr      (dbg_wr),
        .dbg_wdata   (dbg_wdata),
        .err_clr     (err_clr),
        .busy        (busy),
        .timeout_err (timeout_err),
        .level       (level)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        exec_active = 1'b0; halted = 1'b0; err_clr = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        vectors++; if (halt_req !== 1'b0) begin miscompares++; $display("FAIL rst_halt_req got %b exp 0", halt_req); end
        vectors++; if (dbg_wr !== 1'b0) begin miscompares++; $display("FAIL rst_dbg_wr got %b exp 0", dbg_wr); end
        vectors++; if (dbg_addr !== 6'd0) begin miscompares++; $display("FAIL rst_dbg_addr got %h exp 0", dbg_addr); end
        vectors++; if (dbg_wdata !== 32'd0) begin miscompares++; $display("FAIL rst_dbg_wdata got %h exp 0", dbg_wdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
        vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL rst_level got %0d exp 0", level); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err got %b exp 0", timeout_err); end
    endtask

    task automatic test_single_write();
        do_reset();
        cmd_valid = 1'b1; cmd_addr = 6'h04; cmd_data = 32'hDEADBEEF;
        step();
        cmd_valid = 1'b0;
        vectors++; if (level !== 4'd1 || dbg_wr !== 1'b0) begin miscompares++; $display("FAIL single_queued got level=%0d wr=%b exp level=1 wr=0", level, dbg_wr); end
        step();
        vectors++; if (dbg_wr !== 1'b1 || dbg_addr !== 6'h04 || dbg_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_write got wr=%b addr=%h data=%h exp 1/04/deadbeef", dbg_wr, dbg_addr, dbg_wdata); end
        vectors++; if (halt_req !== 1'b0) begin miscompares++; $display("FAIL single_halt_req got %b exp 0", halt_req); end
        step();
        vectors++; if (dbg_wr !== 1'b0 || dbg_addr !== 6'd0 || dbg_wdata !== 32'd0 || halt_req !== 1'b0) begin miscompares++; $display("FAIL single_after got wr=%b addr=%h data=%h halt=%b exp all 0", dbg_wr, dbg_addr, dbg_wdata, halt_req); end
        step();
        vectors++; if (busy !== 1'b0 || level !== 4'd0) begin miscompares++; $display("FAIL single_idle got busy=%b level=%0d exp 0/0", busy, level); end
    endtask

    task automatic test_halt_burst();
        logic [5:0] addrs [3] = '{6'h10, 6'h11, 6'h12};
        logic [31:0] datas [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_reset();
        exec_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_addr = addrs[i]; cmd_data = datas[i];
            step();
        end
        cmd_valid = 1'b0;
        vectors++; if (level !== 4'd3 || halt_req !== 1'b1 || dbg_wr !== 1'b0) begin miscompares++; $display("FAIL burst_queued got level=%0d halt=%b wr=%b exp 3/1/0", level, halt_req, dbg_wr); end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (halt_req !== 1'b1 || dbg_wr !== 1'b0) begin miscompares++; $display("FAIL burst_wait%0d got halt=%b wr=%b exp 1/0", i, halt_req, dbg_wr); end
        end
        halted = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (dbg_wr !== 1'b1 || dbg_addr !== addrs[i] || dbg_wdata !== datas[i] || halt_req !== 1'b1) begin miscompares++; $display("FAIL burst_write%0d got wr=%b addr=%h data=%h halt=%b exp 1/%h/%h/1", i, dbg_wr, dbg_addr, dbg_wdata, halt_req, addrs[i], datas[i]); end
        end
        step();
        vectors++; if (dbg_wr !== 1'b0 || halt_req !== 1'b0 || level !== 4'd0) begin miscompares++; $display("FAIL burst_resume got wr=%b halt=%b level=%0d exp 0/0/0", dbg_wr, halt_req, level); end
        halted = 1'b0;
        step();
        vectors++; if (busy !== 1'b0 || halt_req !== 1'b0) begin miscompares++; $display("FAIL burst_idle got busy=%b halt=%b exp 0/0", busy, halt_req); end
    endtask

    task automatic test_timeout();
        do_reset();
        exec_active = 1'b1;
        cmd_valid = 1'b1; cmd_addr = 6'h20; cmd_data = 32'hCAFEF00D;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++; if (halt_req !== 1'b1 || dbg_wr !== 1'b0) begin miscompares++; $display("FAIL to_wait%0d got halt=%b wr=%b exp 1/0", i, halt_req, dbg_wr); end
        end
        step();
        vectors++; if (cmd_ready !== 1'b0 || halt_req !== 1'b0 || dbg_wr !== 1'b0) begin miscompares++; $display("FAIL to_flush got ready=%b halt=%b wr=%b exp 0/0/0", cmd_ready, halt_req, dbg_wr); end
        step();
        vectors++; if (timeout_err !== 1'b1 || level !== 4'd0 || busy !== 1'b0 || dbg_wr !== 1'b0) begin miscompares++; $display("FAIL to_after got err=%b level=%0d busy=%b wr=%b exp 1/0/0/0", timeout_err, level, busy, dbg_wr); end
        step();
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_clear got %b exp 0", timeout_err); end
    endtask

    task automatic test_full();
        do_reset();
        exec_active = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_addr = 6'h30 + 6'(i); cmd_data = 32'hA0 + 32'(i);
            vectors++; if (cmd_ready !== (i < 4)) begin miscompares++; $display("FAIL full_ready%0d got %b exp %b", i, cmd_ready, i < 4); end
            step();
        end
        cmd_valid = 1'b0;
        vectors++; if (level !== 4'd4) begin miscompares++; $display("FAIL full_level got %0d exp 4", level); end
        halted = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (dbg_wr !== 1'b1 || dbg_addr !== 6'h30 + 6'(i) || dbg_wdata !== 32'hA0 + 32'(i)) begin miscompares++; $display("FAIL full_drain%0d got wr=%b addr=%h data=%h exp 1/%h/%h", i, dbg_wr, dbg_addr, dbg_wdata, 6'h30 + 6'(i), 32'hA0 + 32'(i)); end
        end
        step();
        vectors++; if (dbg_wr !== 1'b0 || level !== 4'd0) begin miscompares++; $display("FAIL full_no5th got wr=%b level=%0d exp 0/0", dbg_wr, level); end
        halted = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmd_valid = 1'b1; cmd_addr = 6'h01; cmd_data = 32'h1;
        step();
        cmd_addr = 6'h02; cmd_data = 32'h2;
        step();
        vectors++; if (level !== 4'd2 || dbg_wr !== 1'b1 || dbg_addr !== 6'h01) begin miscompares++; $display("FAIL b2b_first got level=%0d wr=%b addr=%h exp 2/1/01", level, dbg_wr, dbg_addr); end
        cmd_addr = 6'h03; cmd_data = 32'h3;
        step();
        cmd_valid = 1'b0;
        vectors++; if (level !== 4'd2 || dbg_wr !== 1'b1 || dbg_addr !== 6'h02) begin miscompares++; $display("FAIL b2b_second got level=%0d wr=%b addr=%h exp 2/1/02", level, dbg_wr, dbg_addr); end
        step();
        vectors++; if (dbg_wr !== 1'b1 || dbg_addr !== 6'h03 || dbg_wdata !== 32'h3) begin miscompares++; $display("FAIL b2b_third got wr=%b addr=%h data=%h exp 1/03/3", dbg_wr, dbg_addr, dbg_wdata); end
        step();
        vectors++; if (dbg_wr !== 1'b0 || level !== 4'd0) begin miscompares++; $display("FAIL b2b_end got wr=%b level=%0d exp 0/0", dbg_wr, level); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        exec_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_addr = 6'h38 + 6'(i); cmd_data = 32'h50 + 32'(i);
            step();
        end
        cmd_valid = 1'b0;
        halted = 1'b1;
        step();
        step();
        vectors++; if (dbg_wr !== 1'b1 || dbg_addr !== 6'h39 || halt_req !== 1'b1) begin miscompares++; $display("FAIL mid_second got wr=%b addr=%h halt=%b exp 1/39/1", dbg_wr, dbg_addr, halt_req); end
        rst_n = 1'b0;
        step();
        vectors++; if (halt_req !== 1'b0 || level !== 4'd0 || dbg_wr !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset got halt=%b level=%0d wr=%b busy=%b exp 0/0/0/0", halt_req, level, dbg_wr, busy); end
        rst_n = 1'b1;
        step();
        vectors++; if (dbg_wr !== 1'b0 || halt_req !== 1'b0) begin miscompares++; $display("FAIL mid_after got wr=%b halt=%b exp 0/0", dbg_wr, halt_req); end
        halted = 1'b0; exec_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_halt_burst();
        test_timeout();
        test_full();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
